// File: rtl/float_ldexp_pipe.sv
// ---------------------------------------------------------------------------
// float_ldexp_pipe
//
// Purpose:
//    Two-stage pipelined IEEE-754 scale-by-power-of-two:
//    out_float = (+/-) in_float * 2^in_pow.
//    Infinity and NaN pass through with only the sign changed.
//    Zero passes through.
//    Subnormal inputs are flushed to zero.
//    When the exponent overflows, the result saturates to infinity.
//    When the exponent underflows, the result flushes to zero.
//    Both sides use a valid/ready handshake, and pipeline bubbles collapse.
//
// Parameters:
//    SIZE       float width: 32 (8-bit exponent) or 64 (11-bit exponent)
//    POW_WIDTH  width of the signed two's-complement power input
//
// Ports:
//    clk_in     rising-edge clock
//    rst_n_in   asynchronous active-low reset
//    in_valid   upstream has a transaction
//    in_ready   this block can take a transaction in the current cycle
//    in_float   operand
//    in_pow     signed power of two added to the exponent
//    in_negate  flip the sign of the result
//    out_valid  a result is presented
//    out_ready  downstream accepts the result
//    out_float  result
//    out_ovf    exponent overflow; result saturated to infinity
//    out_unf    exponent underflow or subnormal input; result flushed to zero
// ---------------------------------------------------------------------------
module float_ldexp_pipe #(
    parameter int SIZE      = 32,
    parameter int POW_WIDTH = 12
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SIZE-1:0]      in_float,
    input  logic [POW_WIDTH-1:0] in_pow,
    input  logic                 in_negate,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SIZE-1:0]      out_float,
    output logic                 out_ovf,
    output logic                 out_unf
);

    localparam int EXP_WIDTH  = (SIZE == 64) ? 11 : 8;
    localparam int MANT_WIDTH = SIZE - 1 - EXP_WIDTH;
    // Two spare bits make the exponent sum unable to wrap for any power.
    localparam int NEW_WIDTH  = ((EXP_WIDTH > POW_WIDTH) ? EXP_WIDTH : POW_WIDTH) + 2;

    localparam logic signed [NEW_WIDTH-1:0] EMAX_EXT = NEW_WIDTH'((1 << EXP_WIDTH) - 1);
    localparam logic signed [NEW_WIDTH-1:0] ZERO_EXT = '0;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_SPECIAL,
        CLS_NORMAL
    } expClass_e;

    // Stage 1 state
    logic                        s1Valid_q;
    logic                        s1Sign_q, s1Sign_d;
    logic [MANT_WIDTH-1:0]       s1Mant_q;
    expClass_e                   s1Class_q, s1Class_d;
    logic signed [NEW_WIDTH-1:0] s1NewExp_q, s1NewExp_d;

    // Stage 2 state
    logic                        outValid_q;
    logic [SIZE-1:0]             outFloat_q, outFloat_d;
    logic                        outOvf_q, outOvf_d;
    logic                        outUnf_q, outUnf_d;

    logic                        s1En;
    logic                        s2En;
    logic [EXP_WIDTH-1:0]        inExp;

    assign s2En      = ~outValid_q | out_ready;
    assign s1En      = ~s1Valid_q | s2En;
    assign in_ready  = s1En;
    assign out_valid = outValid_q;
    assign out_float = outFloat_q;
    assign out_ovf   = outOvf_q;
    assign out_unf   = outUnf_q;

    assign inExp = in_float[SIZE-2 -: EXP_WIDTH];

    // Stage 1 decode.
    // Classify the exponent field.
    // Form the widened signed exponent sum.
    always_comb begin
        s1Sign_d   = in_float[SIZE-1] ^ in_negate;
        s1Class_d  = CLS_NORMAL;
        if (inExp == '0) begin
            s1Class_d = CLS_ZERO;
        end else if (inExp == '1) begin
            s1Class_d = CLS_SPECIAL;
        end
        s1NewExp_d = $signed({{(NEW_WIDTH - EXP_WIDTH){1'b0}}, inExp})
                   + $signed({{(NEW_WIDTH - POW_WIDTH){in_pow[POW_WIDTH-1]}}, in_pow});
    end

    // The stage 1 valid register follows the input whenever the stage can advance.
    // An empty stage 1 keeps accepting data even while the output is stalled.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1Valid_q <= 1'b0;
        end else if (s1En) begin
            s1Valid_q <= in_valid;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1Sign_q   <= 1'b0;
            s1Mant_q   <= '0;
            s1Class_q  <= CLS_ZERO;
            s1NewExp_q <= '0;
        end else if (s1En && in_valid) begin
            s1Sign_q   <= s1Sign_d;
            s1Mant_q   <= in_float[MANT_WIDTH-1:0];
            s1Class_q  <= s1Class_d;
            s1NewExp_q <= s1NewExp_d;
        end
    end

    // Stage 2 pack.
    // The default case produces a signed zero with no flags.
    always_comb begin
        outFloat_d = {s1Sign_q, {EXP_WIDTH{1'b0}}, {MANT_WIDTH{1'b0}}};
        outOvf_d   = 1'b0;
        outUnf_d   = 1'b0;
        case (s1Class_q)
            CLS_SPECIAL: begin
                outFloat_d = {s1Sign_q, {EXP_WIDTH{1'b1}}, s1Mant_q};
            end
            CLS_ZERO: begin
                outUnf_d = |s1Mant_q;
            end
            CLS_NORMAL: begin
                if (s1NewExp_q >= EMAX_EXT) begin
                    outFloat_d = {s1Sign_q, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
                    outOvf_d   = 1'b1;
                end else if (s1NewExp_q <= ZERO_EXT) begin
                    outUnf_d   = 1'b1;
                end else begin
                    outFloat_d = {s1Sign_q, s1NewExp_q[EXP_WIDTH-1:0], s1Mant_q};
                end
            end
            default: begin
                outFloat_d = {s1Sign_q, {EXP_WIDTH{1'b0}}, {MANT_WIDTH{1'b0}}};
            end
        endcase
    end

    // The output valid register moves with stage 2.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            outValid_q <= 1'b0;
        end else if (s2En) begin
            outValid_q <= s1Valid_q;
        end
    end

    // Output data only changes when a new result enters stage 2.
    // This keeps the data stable while the output is stalled.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            outFloat_q <= '0;
            outOvf_q   <= 1'b0;
            outUnf_q   <= 1'b0;
        end else if (s2En && s1Valid_q) begin
            outFloat_q <= outFloat_d;
            outOvf_q   <= outOvf_d;
            outUnf_q   <= outUnf_d;
        end
    end

endmodule
